// File: rtl/prio_enc_scan_disp_if.sv
// rtl/prio_enc_scan_disp_if.sv - request/display bundle for prio_enc_scan_disp
//
// Purpose: groups the encoder request inputs and the encoded/display outputs.
// Parameters: N (request width), NDIG (scanned digit count).
// Signals:
//   x    [N-1:0]    raw request vector
//   en              encoder enable
//   idx  [IW-1:0]   accepted highest-set-bit index (IW = clog2(N))
//   flag            accepted en=1 and accepted x!=0
//   chg             one-cycle pulse when {idx,flag} changes
//   seg  [6:0]      active-low segments, bit6=a .. bit0=g
//   an   [NDIG-1:0] active-low digit select
// Modports: master drives x/en (board side), slave is the encoder.
interface prio_enc_scan_disp_if #(
  parameter int N    = 8,
  parameter int NDIG = 2
);
  localparam int IW = $clog2(N);

  logic [N-1:0]    x;
  logic            en;
  logic [IW-1:0]   idx;
  logic            flag;
  logic            chg;
  logic [6:0]      seg;
  logic [NDIG-1:0] an;

  modport master (output x, en, input idx, flag, chg, seg, an);
  modport slave  (input x, en, output idx, flag, chg, seg, an);
endinterface

// File: rtl/prio_enc_scan_disp.sv
// rtl/prio_enc_scan_disp.sv - debounced priority encoder with scanned hex display
//
// Purpose: debounces {en,x}, encodes the highest set bit of the accepted value
// into a registered idx/flag with a change pulse, and shows idx in hex on NDIG
// time-multiplexed seven-segment digits.
// Ports:
//   clk  rising-edge system clock
//   rst  asynchronous active-high reset
//   bus  prio_enc_scan_disp_if.slave (x, en in; idx, flag, chg, seg, an out)
// Parameters: N (>=2), NDIG (4*NDIG >= clog2(N)), DB_CYCLES (>=1), SCAN_DIV (>=1).
// Optional: define PRIO_ENC_LEAD_ZERO_BLANK_EN to blank digits above the most
// significant non-zero nibble of idx (digit 0 is never blanked).
module prio_enc_scan_disp #(
  parameter int N         = 8,
  parameter int NDIG      = 2,
  parameter int DB_CYCLES = 4,
  parameter int SCAN_DIV  = 1000
) (
  input logic                clk,
  input logic                rst,
  prio_enc_scan_disp_if.slave bus
);
  localparam int IW   = $clog2(N);
  localparam int XW   = N + 1;
  localparam int CW   = $clog2(DB_CYCLES + 1);
  localparam int DW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int PW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int PADW = 4 * NDIG;

  logic [XW-1:0]   raw;
  logic [XW-1:0]   cand;
  logic [XW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic [IW-1:0]   idx_q;
  logic            flag_q;
  logic            chg_q;
  logic [IW-1:0]   cand_idx;
  logic            cand_flag;
  logic [IW-1:0]   acc_idx;
  logic            acc_flag;
  logic [DW-1:0]   div;
  logic [PW-1:0]   ptr;
  logic [PADW-1:0] idx_pad;
  logic [3:0]      nib;
  logic [6:0]      seg_c;
  logic [NDIG-1:0] an_c;

  // {idx,flag} for a {en,x} word; idx is forced to 0 whenever flag is 0.
  function automatic logic [IW:0] encode(input logic [XW-1:0] v);
    logic [IW-1:0] hi;
    logic          f;
    hi = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) hi = IW'(i);
    end
    f = v[N] & (|v[N-1:0]);
    return {(f ? hi : {IW{1'b0}}), f};
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'ha: glyph = 7'b0001000;
      4'hb: glyph = 7'b1100000;
      4'hc: glyph = 7'b0110001;
      4'hd: glyph = 7'b1000010;
      4'he: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  assign raw = {bus.en, bus.x};
  assign {cand_idx, cand_flag} = encode(cand);
  // acc always encodes to the current idx/flag, so it serves as the "previous"
  // value for the change pulse.
  assign {acc_idx, acc_flag} = encode(acc);

  // cnt counts edges on which the sample matched the previous one; reaching
  // DB_CYCLES-1 on a further matching edge means DB_CYCLES+1 identical samples.
  assign accept = (raw == cand) && (cnt == CW'(DB_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand   <= '0;
      cnt    <= '0;
      acc    <= '0;
      idx_q  <= '0;
      flag_q <= 1'b0;
      chg_q  <= 1'b0;
    end else begin
      cand  <= raw;
      chg_q <= 1'b0;
      if (raw != cand) begin
        cnt <= '0;
      end else if (cnt != CW'(DB_CYCLES)) begin
        cnt <= cnt + CW'(1);
      end
      if (accept) begin
        acc    <= cand;
        idx_q  <= cand_idx;
        flag_q <= cand_flag;
        chg_q  <= ({cand_idx, cand_flag} != {acc_idx, acc_flag});
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
      ptr <= '0;
    end else if (div == DW'(SCAN_DIV - 1)) begin
      div <= '0;
      ptr <= (ptr == PW'(NDIG - 1)) ? '0 : ptr + PW'(1);
    end else begin
      div <= div + DW'(1);
    end
  end

  assign idx_pad = PADW'(idx_q);

`ifdef PRIO_ENC_LEAD_ZERO_BLANK_EN
  logic upper_nz;
`endif

  always_comb begin
    an_c = '1;
    nib  = '0;
`ifdef PRIO_ENC_LEAD_ZERO_BLANK_EN
    upper_nz = 1'b0;
`endif
    for (int d = 0; d < NDIG; d++) begin
      if (PW'(d) == ptr) begin
        an_c[d] = 1'b0;
        nib     = idx_pad[4*d +: 4];
      end
`ifdef PRIO_ENC_LEAD_ZERO_BLANK_EN
      if ((PW'(d) > ptr) && (idx_pad[4*d +: 4] != 4'h0)) upper_nz = 1'b1;
`endif
    end
    seg_c = glyph(nib);
`ifdef PRIO_ENC_LEAD_ZERO_BLANK_EN
    // A zero nibble with nothing non-zero above it is a leading zero.
    if ((ptr != '0) && (nib == 4'h0) && !upper_nz) seg_c = 7'b1111111;
`endif
  end

  assign bus.idx  = idx_q;
  assign bus.flag = flag_q;
  assign bus.chg  = chg_q;
  assign bus.seg  = seg_c;
  assign bus.an   = an_c;
endmodule

// File: tb/tb_prio_enc_scan_disp.sv
// tb/tb_prio_enc_scan_disp.sv - self-checking bench for prio_enc_scan_disp
module tb_prio_enc_scan_disp;
  localparam int DB   = 4;
  localparam int SD   = 3;
  localparam int NDIG = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prio_enc_scan_disp_if #(.N(8),  .NDIG(NDIG)) if8();
  prio_enc_scan_disp_if #(.N(32), .NDIG(NDIG)) if32();

  prio_enc_scan_disp #(.N(8), .NDIG(NDIG), .DB_CYCLES(DB), .SCAN_DIV(SD)) dut8 (
    .clk(clk), .rst(rst), .bus(if8)
  );
  prio_enc_scan_disp #(.N(32), .NDIG(NDIG), .DB_CYCLES(DB), .SCAN_DIV(SD)) dut32 (
    .clk(clk), .rst(rst), .bus(if32)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [6:0] glyph_tab [16];

  // Reference model for dut8: run length of identical {en,x} samples.
  logic [8:0] m_lv;
  int         m_run;
  int         e_idx;
  logic       e_flag;
  logic       e_chg;
  int         cyc;

  function automatic int hi_bit(int v);
    return $clog2(v + 1) - 1;
  endfunction

  function automatic int exp_ptr();
    return (cyc / SD) % NDIG;
  endfunction

  function automatic logic [NDIG-1:0] exp_an(int p);
    return ~(NDIG'(1) << p);
  endfunction

  function automatic logic [6:0] exp_seg(int v, int p);
    int nib = (v >> (4 * p)) & 15;
`ifdef PRIO_ENC_LEAD_ZERO_BLANK_EN
    if (p != 0 && (v >> (4 * p)) == 0) return 7'b1111111;
`endif
    return glyph_tab[nib];
  endfunction

  task automatic model_reset();
    m_lv   = '0;
    m_run  = 1;
    e_idx  = 0;
    e_flag = 1'b0;
    e_chg  = 1'b0;
    cyc    = 0;
  endtask

  // Advance one clock, update the model, return at the falling edge.
  task automatic tick();
    logic [8:0] raw;
    int   ni;
    logic nf;
    @(posedge clk);
    raw = {if8.en, if8.x};
    if (raw == m_lv) m_run++;
    else begin
      m_lv  = raw;
      m_run = 1;
    end
    e_chg = 1'b0;
    if (m_run == DB + 1) begin
      nf = raw[8] && (raw[7:0] != 0);
      ni = nf ? hi_bit(int'(raw[7:0])) : 0;
      e_chg  = (ni != e_idx) || (nf != e_flag);
      e_idx  = ni;
      e_flag = nf;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if8.x = '0;  if8.en = 1'b0;
    if32.x = '0; if32.en = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (if8.idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx: got %0d exp 0", if8.idx); end
    n_checks++; if (if8.flag !== 1'b0) begin n_fail++; $display("FAIL reset_flag: got %0b exp 0", if8.flag); end
    n_checks++; if (if8.chg !== 1'b0) begin n_fail++; $display("FAIL reset_chg: got %0b exp 0", if8.chg); end
    n_checks++; if (if8.an !== 2'b10) begin n_fail++; $display("FAIL reset_an: got %b exp 10", if8.an); end
    n_checks++; if (if8.seg !== 7'b0000001) begin n_fail++; $display("FAIL reset_seg: got %b exp 0000001", if8.seg); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_latency();
    repeat (6) begin
      tick();
      n_checks++; if (if8.chg !== 1'b0) begin n_fail++; $display("FAIL lat_idle_chg: got %0b exp 0", if8.chg); end
    end
    if8.en = 1'b1; if8.x = 8'b0010_0100;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++; if (if8.flag !== (k >= 5)) begin n_fail++; $display("FAIL lat_flag edge %0d: got %0b exp %0b", k, if8.flag, k >= 5); end
      n_checks++; if (if8.idx !== ((k >= 5) ? 3'd5 : 3'd0)) begin n_fail++; $display("FAIL lat_idx edge %0d: got %0d", k, if8.idx); end
      n_checks++; if (if8.chg !== (k == 5)) begin n_fail++; $display("FAIL lat_chg edge %0d: got %0b exp %0b", k, if8.chg, k == 5); end
    end
  endtask

  task automatic test_glitch();
    if8.x = 8'h01;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++; if (if8.chg !== (k == 5)) begin n_fail++; $display("FAIL gl_acc_chg edge %0d: got %0b exp %0b", k, if8.chg, k == 5); end
    end
    n_checks++; if (if8.idx !== 3'd0 || if8.flag !== 1'b1) begin n_fail++; $display("FAIL gl_acc: got idx %0d flag %0b exp 0/1", if8.idx, if8.flag); end
    // 3-cycle pulse, then a change landing on the would-be accept edge.
    for (int ph = 0; ph < 2; ph++) begin
      if8.x = 8'h80;
      repeat (ph == 0 ? 3 : 4) begin
        tick();
        n_checks++; if (if8.idx !== 3'd0 || if8.flag !== 1'b1 || if8.chg !== 1'b0) begin n_fail++; $display("FAIL gl_pulse ph%0d: got idx %0d flag %0b chg %0b", ph, if8.idx, if8.flag, if8.chg); end
      end
      if (ph == 1) begin
        if8.x = 8'h40;
        tick();
        n_checks++; if (if8.idx !== 3'd0 || if8.chg !== 1'b0) begin n_fail++; $display("FAIL gl_blocked: got idx %0d chg %0b exp 0/0", if8.idx, if8.chg); end
      end
      if8.x = 8'h01;
      repeat (8) begin
        tick();
        n_checks++; if (if8.idx !== 3'd0 || if8.flag !== 1'b1 || if8.chg !== 1'b0) begin n_fail++; $display("FAIL gl_back ph%0d: got idx %0d flag %0b chg %0b", ph, if8.idx, if8.flag, if8.chg); end
      end
    end
  endtask

  task automatic test_disable();
    if8.x = 8'hFF; if8.en = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++; if (if8.flag !== (k < 5)) begin n_fail++; $display("FAIL dis_flag edge %0d: got %0b exp %0b", k, if8.flag, k < 5); end
      n_checks++; if (if8.idx !== 3'd0) begin n_fail++; $display("FAIL dis_idx edge %0d: got %0d exp 0", k, if8.idx); end
      n_checks++; if (if8.chg !== (k == 5)) begin n_fail++; $display("FAIL dis_chg edge %0d: got %0b exp %0b", k, if8.chg, k == 5); end
    end
    repeat (3) begin
      if8.x = 8'($urandom_range(1, 255));
      repeat (6) begin
        tick();
        n_checks++; if (if8.chg !== 1'b0 || if8.flag !== 1'b0) begin n_fail++; $display("FAIL dis_hold: got chg %0b flag %0b exp 0/0", if8.chg, if8.flag); end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      if8.en = ($urandom_range(0, 7) != 0);
      if8.x  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      repeat ($urandom_range(1, 7)) begin
        tick();
        n_checks++; if (if8.idx !== 3'(e_idx)) begin n_fail++; $display("FAIL rnd_idx: got %0d exp %0d", if8.idx, e_idx); end
        n_checks++; if (if8.flag !== e_flag) begin n_fail++; $display("FAIL rnd_flag: got %0b exp %0b", if8.flag, e_flag); end
        n_checks++; if (if8.chg !== e_chg) begin n_fail++; $display("FAIL rnd_chg: got %0b exp %0b", if8.chg, e_chg); end
        n_checks++; if (if8.an !== exp_an(exp_ptr())) begin n_fail++; $display("FAIL rnd_an: got %b exp %b", if8.an, exp_an(exp_ptr())); end
        n_checks++; if (if8.seg !== exp_seg(e_idx, exp_ptr())) begin n_fail++; $display("FAIL rnd_seg: got %b exp %b", if8.seg, exp_seg(e_idx, exp_ptr())); end
      end
    end
  endtask

  task automatic test_async_reset();
    if8.en = 1'b1; if8.x = 8'h40;
    repeat (7) tick();
    if8.x = 8'h03;
    repeat (2) tick();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (if8.idx !== 3'd0 || if8.flag !== 1'b0 || if8.chg !== 1'b0) begin n_fail++; $display("FAIL arst_out: got idx %0d flag %0b chg %0b", if8.idx, if8.flag, if8.chg); end
    n_checks++; if (if8.an !== 2'b10 || if8.seg !== 7'b0000001) begin n_fail++; $display("FAIL arst_disp: got an %b seg %b", if8.an, if8.seg); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++; if (if8.flag !== (k >= 5) || if8.idx !== 3'(e_idx)) begin n_fail++; $display("FAIL arst_redb edge %0d: got idx %0d flag %0b", k, if8.idx, if8.flag); end
      n_checks++; if (if8.chg !== e_chg) begin n_fail++; $display("FAIL arst_chg edge %0d: got %0b exp %0b", k, if8.chg, e_chg); end
    end
  endtask

  task automatic test_scan_disp(input int bit_pos, input int exp_val, input string tag);
    if32.en = 1'b1;
    if32.x  = 32'd1 << bit_pos;
    repeat (6) tick();
    n_checks++; if (if32.idx !== 5'(exp_val) || if32.flag !== 1'b1) begin n_fail++; $display("FAIL %s_idx: got %0d flag %0b exp %0d", tag, if32.idx, if32.flag, exp_val); end
    repeat (4 * SD * NDIG) begin
      tick();
      n_checks++; if (if32.an !== exp_an(exp_ptr())) begin n_fail++; $display("FAIL %s_an: got %b exp %b", tag, if32.an, exp_an(exp_ptr())); end
      n_checks++; if (if32.seg !== exp_seg(exp_val, exp_ptr())) begin n_fail++; $display("FAIL %s_seg ptr %0d: got %b exp %b", tag, exp_ptr(), if32.seg, exp_seg(exp_val, exp_ptr())); end
    end
  endtask

  initial begin
    glyph_tab[0]  = 7'b0000001; glyph_tab[1]  = 7'b1001111;
    glyph_tab[2]  = 7'b0010010; glyph_tab[3]  = 7'b0000110;
    glyph_tab[4]  = 7'b1001100; glyph_tab[5]  = 7'b0100100;
    glyph_tab[6]  = 7'b0100000; glyph_tab[7]  = 7'b0001111;
    glyph_tab[8]  = 7'b0000000; glyph_tab[9]  = 7'b0000100;
    glyph_tab[10] = 7'b0001000; glyph_tab[11] = 7'b1100000;
    glyph_tab[12] = 7'b0110001; glyph_tab[13] = 7'b1000010;
    glyph_tab[14] = 7'b0110000; glyph_tab[15] = 7'b0111000;
    test_reset();
    test_latency();
    test_glitch();
    test_disable();
    test_random();
    test_async_reset();
    test_scan_disp(31, 31, "scan");
    test_scan_disp(3, 3, "blank");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/prio_enc_scan_disp.md
Name: prio_enc_scan_disp

Overview:
- Parametrised successor to the 8-to-3 priority encoder with seven-segment output.
- Takes an N-bit request vector plus enable and debounces it. Encodes the highest set bit into a registered index with a valid flag and a change pulse.
- Shows the index in hex on NDIG time-multiplexed seven-segment digits.
- Sits between board switches/buttons and the LED/segment pins in npc top-level.

Parameters:
- N, 8: request vector width, ≥2. Index width IW = clog2(N) (local).
- NDIG, 2: number of scanned digits. 4*NDIG ≥ IW required.
- DB_CYCLES, 4: consecutive stable cycles needed before a new input is accepted, ≥1.
- SCAN_DIV, 1000: clock cycles per digit slot, ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- x  input  N  raw request vector (asynchronous to logic meaning, sampled on clk).
- en  input  1  encoder enable.
- idx  output  IW  index of highest set bit of accepted x. 0 when flag=0.
- flag  output  1  1 iff accepted en=1 and accepted x≠0.
- chg  output  1  one-cycle pulse when {idx,flag} changes.
- seg  output  7  active-low segments; bit6=a … bit0=g.
- an  output  NDIG  active-low digit select, one-hot-low.

Behaviour:
- Reset (async, immediate) values:
  - idx=0, flag=0, chg=0.
  - cand=0, cnt=0, acc=0.
  - div=0, ptr=0.
  - Outputs therefore reset to an = all 1 except bit0 = 0, and seg = 7'b0000001.
- Debounce:
  - Candidate register cand holds {en,x} and is loaded every edge.
  - On edges where raw≠cand, cnt←0.
  - On edges where raw==cand, cnt increments, saturating at DB_CYCLES.
  - Accept edge: raw==cand and cnt==DB_CYCLES-1. On this edge acc←cand, and idx/flag are loaded from the encoding of cand.
  - A raw change on what would have been the accept edge blocks acceptance and restarts the count.
  - Latency: a new value held stable is visible on idx/flag after exactly DB_CYCLES+1 rising edges, counting the first edge that samples it.
  - Shorter pulses are never accepted.
- Encoding:
  - idx = highest i with x[i]=1 when en=1 and x≠0; otherwise idx=0 and flag=0.
  - Ties are impossible; the highest index wins.
- chg:
  - Registered; high for exactly the one cycle following an accept edge whose new {idx,flag} differs from the previous value.
  - Re-accepting an identical value gives no pulse.
  - A different x with the same idx (e.g. lower bits changing) gives no pulse.
- Scan:
  - div counts 0..SCAN_DIV-1 and wraps.
  - On wrap, ptr advances 0..NDIG-1 and wraps to 0.
- Display outputs:
  - an, seg are combinational from ptr and idx.
  - an[ptr]=0; all other an bits are 1.
  - seg shows the hex glyph of nibble ptr of idx, zero-extended to 4*NDIG bits.
  - seg follows idx in the same cycle idx updates; no glitch-free requirement.
- Hex glyphs (abcdefg, active-low):

  | Value | Glyph | Value | Glyph |
  |---|---|---|---|
  | 0 | 0000001 | 8 | 0000000 |
  | 1 | 1001111 | 9 | 0000100 |
  | 2 | 0010010 | A | 0001000 |
  | 3 | 0000110 | b | 1100000 |
  | 4 | 1001100 | C | 0110001 |
  | 5 | 0100100 | d | 1000010 |
  | 6 | 0100000 | E | 0110000 |
  | 7 | 0001111 | F | 0111000 |

- Reset mid-debounce or mid-scan:
  - All state clears immediately.
  - After release, the input is re-debounced from cnt=0.
  - No chg is produced by reset itself.

Optional Feature:
- Macro PRIO_ENC_LEAD_ZERO_BLANK_EN.
- Defined: any digit above the most significant non-zero nibble of idx drives seg=7'b1111111 (blank). an scanning is unchanged, and digit 0 is never blanked.
- Undefined: all digits always show their glyph, leading zeros included.

Test Plan:
- Reset: assert rst asynchronously mid-cycle → idx=0, flag=0, chg=0, an=2'b10, seg=7'b0000001 without waiting for a clock edge.
- Debounce latency (N=8, DB_CYCLES=4): en=1, x=8'b0010_0100 held → idx=5, flag=1 after exactly 5 edges; chg=1 for one cycle only.
- Glitch reject: x=8'h01 accepted; x=8'h80 for 3 cycles, then back to 8'h01 → idx stays 0, flag=1, chg never pulses. Also a change on the would-be accept edge → no acceptance.
- Disable: x=8'hFF, en=0 held → idx=0, flag=0 after 5 edges with a chg pulse. x changes while en=0 → no further chg.
- Scan (N=32, NDIG=2, SCAN_DIV=3): idx=31 → an=10 with seg=0111000 for 3 cycles, then an=01 with seg=1001111, alternating.
- Macro defined (N=32): idx=3 → digit1 seg=1111111, digit0 seg=0000110. Macro undefined → digit1 seg=0000001.
